// File: rtl/intr_ctrl.sv
// Prioritised interrupt controller: per-channel edge/level capture, mask, fixed
// priority (lowest index wins) and an intr/ack/eoi handshake with the CPU.
module intr_ctrl #(
    parameter int                   NUM_IRQ    = 8,
    parameter int                   ID_W       = 3,
    parameter logic [NUM_IRQ-1:0]   EDGE_MASK  = NUM_IRQ'(8'hF0),
    parameter logic [31:0]          VEC_BASE   = 32'h0000_0400,
    parameter int                   VEC_STRIDE = 8,
    parameter logic [NUM_IRQ-1:0]   MASK_RST   = '1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               ie,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    output logic [NUM_IRQ-1:0] mask_q,
    output logic [NUM_IRQ-1:0] pending_q,
    output logic               intr,
    input  logic               intr_ack,
    output logic [ID_W-1:0]    intr_id,
    output logic [31:0]        intr_vec,
    input  logic               eoi,
    output logic               in_service
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_e;

    state_e             state_q, state_d;
    logic [NUM_IRQ-1:0] irq_prev_q, irq_prev_d;
    logic [NUM_IRQ-1:0] pending_d, mask_d, eligible;
    logic               intr_q, intr_d;
    logic               in_service_q, in_service_d;
    logic [ID_W-1:0]    intr_id_q, intr_id_d, winner;
    logic [31:0]        intr_vec_q, intr_vec_d;
    logic               ack_fire;

    assign intr       = intr_q;
    assign intr_id    = intr_id_q;
    assign intr_vec   = intr_vec_q;
    assign in_service = in_service_q;

    always_comb begin
        state_d      = state_q;
        intr_d       = intr_q;
        in_service_d = in_service_q;
        intr_id_d    = intr_id_q;
        intr_vec_d   = intr_vec_q;
        irq_prev_d   = irq;
        mask_d       = mask_we ? mask_wdata : mask_q;
        ack_fire     = (state_q == REQ) && intr_ack;
        eligible     = pending_q & mask_q;

        // Edge set wins over the ack clear; level channels simply follow the line.
        pending_d = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (EDGE_MASK[i]) begin
                pending_d[i] = (irq[i] & ~irq_prev_q[i]) |
                               (pending_q[i] & ~(ack_fire && (intr_id_q == ID_W'(i))));
            end else begin
                pending_d[i] = irq[i];
            end
        end

        winner = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) winner = ID_W'(i);
        end

        case (state_q)
            IDLE: begin
                if (ie && (eligible != '0)) begin
                    state_d    = REQ;
                    intr_d     = 1'b1;
                    intr_id_d  = winner;
                    intr_vec_d = VEC_BASE + 32'(winner) * 32'(VEC_STRIDE);
                end
            end
            REQ: begin
                // Request is frozen until acked; eoi here is deliberately ignored.
                if (intr_ack) begin
                    state_d      = SERVICE;
                    intr_d       = 1'b0;
                    in_service_d = 1'b1;
                end
            end
            SERVICE: begin
                if (eoi) begin
                    state_d      = IDLE;
                    in_service_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            intr_q       <= 1'b0;
            in_service_q <= 1'b0;
            intr_id_q    <= '0;
            intr_vec_q   <= VEC_BASE;
            pending_q    <= '0;
            irq_prev_q   <= '0;
            mask_q       <= MASK_RST;
        end else begin
            state_q      <= state_d;
            intr_q       <= intr_d;
            in_service_q <= in_service_d;
            intr_id_q    <= intr_id_d;
            intr_vec_q   <= intr_vec_d;
            pending_q    <= pending_d;
            irq_prev_q   <= irq_prev_d;
            mask_q       <= mask_d;
        end
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: directed handshake scenarios plus random traffic, compared
// against a behavioural model; each new request is scoreboarded as {id, vec}.
module tb_intr_ctrl;

    localparam int          N     = 8;
    localparam int          IDW   = 3;
    localparam logic [7:0]  EDGE  = 8'hF0;
    localparam logic [31:0] VBASE = 32'h0000_0400;
    localparam int          VSTR  = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   irq = '0;
    logic           ie = 1'b0;
    logic           mask_we = 1'b0;
    logic [N-1:0]   mask_wdata = '0;
    logic           intr_ack = 1'b0;
    logic           eoi = 1'b0;
    logic [N-1:0]   mask_q, pending_q;
    logic           intr, in_service;
    logic [IDW-1:0] intr_id;
    logic [31:0]    intr_vec;

    intr_ctrl dut (
        .clk(clk), .rst(rst), .irq(irq), .ie(ie), .mask_we(mask_we),
        .mask_wdata(mask_wdata), .mask_q(mask_q), .pending_q(pending_q),
        .intr(intr), .intr_ack(intr_ack), .intr_id(intr_id), .intr_vec(intr_vec),
        .eoi(eoi), .in_service(in_service)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [IDW+31:0] exp_q[$];

    // Reference model: mode 0 = waiting, 1 = requesting, 2 = servicing
    int          m_mode;
    logic [7:0]  m_pend, m_mask, m_last_irq;
    int          m_id;
    logic [31:0] m_vec;
    logic        m_intr, m_insvc;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void model_step();
        logic [7:0] elig, nxt;
        if (rst) begin
            m_mode = 0; m_pend = '0; m_mask = 8'hFF; m_last_irq = '0;
            m_id = 0; m_vec = VBASE; m_intr = 1'b0; m_insvc = 1'b0;
            return;
        end
        elig = m_pend & m_mask;
        for (int i = 0; i < N; i++) begin
            if (EDGE[i]) begin
                bit rise = irq[i] && !m_last_irq[i];
                bit clr  = (m_mode == 1) && intr_ack && (m_id == i);
                nxt[i] = rise || (m_pend[i] && !clr);
            end else begin
                nxt[i] = irq[i];
            end
        end
        if (m_mode == 0) begin
            if (ie && elig != 0) begin
                int w = 0;
                while (!elig[w]) w++;
                m_id = w;
                m_vec = VBASE + w * VSTR;
                m_intr = 1'b1;
                m_mode = 1;
                exp_q.push_back({IDW'(w), m_vec});
            end
        end else if (m_mode == 1) begin
            if (intr_ack) begin
                m_mode = 2; m_intr = 1'b0; m_insvc = 1'b1;
            end
        end else if (eoi) begin
            m_mode = 0; m_insvc = 1'b0;
        end
        m_pend = nxt;
        if (mask_we) m_mask = mask_wdata;
        m_last_irq = irq;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("pending_q", 32'(pending_q), 32'(m_pend));
        check("mask_q", 32'(mask_q), 32'(m_mask));
        check("intr", 32'(intr), 32'(m_intr));
        check("in_service", 32'(in_service), 32'(m_insvc));
        check("intr_id", 32'(intr_id), 32'(m_id));
        check("intr_vec", intr_vec, m_vec);
    endtask

    task automatic pulse_irq(input logic [7:0] v);
        irq = v; tick(); irq = '0;
    endtask

    task automatic do_ack();
        intr_ack = 1'b1; tick(); intr_ack = 1'b0;
    endtask

    task automatic do_eoi();
        eoi = 1'b1; tick(); eoi = 1'b0;
    endtask

    // Scoreboard monitor: every rising intr must match the oldest expected request
    logic prev_intr = 1'b0;
    always @(negedge clk) begin
        if (intr === 1'b1 && prev_intr !== 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_unexpected_req: got id=%0d vec=%h expected none", intr_id, intr_vec);
            end else begin
                logic [IDW+31:0] e;
                e = exp_q.pop_front();
                check("sb_req", {29'd0, intr_id, intr_vec}, {29'd0, e});
            end
        end
        prev_intr = intr;
    end

    initial begin
        @(negedge clk);
        rst = 1'b1; tick(); tick();
        check("rst_intr_vec", intr_vec, 32'h0000_0400);
        check("rst_mask", 32'(mask_q), 32'hFF);
        rst = 1'b0;

        // Edge channel 4 pulse
        ie = 1'b1;
        pulse_irq(8'h10);
        check("s1_pending", 32'(pending_q), 32'h10);
        tick();
        check("s1_intr", 32'(intr), 32'd1);
        check("s1_vec", intr_vec, 32'h0000_0420);
        do_ack();
        check("s1_insvc", 32'(in_service), 32'd1);
        check("s1_pend_clr", 32'(pending_q), 32'h00);
        do_eoi();
        check("s1_insvc_off", 32'(in_service), 32'd0);

        // Level channels 1 and 3
        irq = 8'h0A; tick(); tick();
        check("s2_id1", 32'(intr_id), 32'd1);
        check("s2_vec1", intr_vec, 32'h0000_0408);
        do_ack();
        irq = 8'h08; tick();
        do_eoi();
        check("s2_idle_gap", 32'(intr), 32'd0);
        tick();
        check("s2_id3", 32'(intr_id), 32'd3);
        check("s2_vec3", intr_vec, 32'h0000_0418);
        do_ack();
        irq = 8'h00; tick();
        do_eoi();

        // Masking holds pending without requesting
        mask_we = 1'b1; mask_wdata = 8'hEF; irq = 8'h10; tick();
        mask_we = 1'b0; irq = 8'h00; tick(); tick(); tick();
        check("s3_masked_pend", 32'(pending_q), 32'h10);
        check("s3_masked_intr", 32'(intr), 32'd0);
        mask_we = 1'b1; mask_wdata = 8'hFF; tick(); mask_we = 1'b0; tick();
        check("s3_unmask_id", 32'(intr_id), 32'd4);
        do_ack(); do_eoi();

        // No re-arbitration while requesting
        pulse_irq(8'h20); tick();
        irq = 8'h01; tick(); tick();
        check("s4_hold_id5", 32'(intr_id), 32'd5);
        do_ack(); do_eoi(); tick();
        check("s4_then_id0", 32'(intr_id), 32'd0);
        do_ack();
        irq = 8'h00; tick();
        do_eoi();

        // ie gating, and an edge coincident with the ack
        ie = 1'b0;
        pulse_irq(8'h20);
        for (int i = 0; i < 6; i++) tick();
        check("s5_ie_off", 32'(intr), 32'd0);
        ie = 1'b1; tick();
        check("s5_id5", 32'(intr_id), 32'd5);
        irq = 8'h20; intr_ack = 1'b1; tick(); intr_ack = 1'b0; irq = 8'h00;
        check("s5_set_wins", 32'(pending_q), 32'h20);
        do_eoi(); tick(); do_ack(); do_eoi();

        // Reset in service with pending 8'h80 and a non-default mask
        pulse_irq(8'h80); tick(); do_ack();
        mask_we = 1'b1; mask_wdata = 8'h7F; pulse_irq(8'h80); mask_we = 1'b0;
        check("s6_pend80", 32'(pending_q), 32'h80);
        rst = 1'b1; tick(); rst = 1'b0;
        check("s6_rst_mask", 32'(mask_q), 32'hFF);
        check("s6_rst_pend", 32'(pending_q), 32'h00);
        check("s6_rst_insvc", 32'(in_service), 32'd0);
        for (int i = 0; i < 4; i++) tick();
        check("s6_no_intr", 32'(intr), 32'd0);

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            irq = 8'($urandom_range(0, 255) & $urandom_range(0, 255) & $urandom_range(0, 255));
            ie = ($urandom_range(0, 9) != 0);
            mask_we = ($urandom_range(0, 29) == 0);
            mask_wdata = 8'($urandom_range(0, 255) | $urandom_range(0, 255));
            intr_ack = (m_mode == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            eoi = (m_mode == 2) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        irq = '0; ie = 1'b0; mask_we = 1'b0; intr_ack = 1'b0; eoi = 1'b0; rst = 1'b0;
        tick(); tick();
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
- Parametrised, prioritised interrupt controller between N external interrupt sources and the pipelined CPU's single intr/intr_ack/LISR interrupt path.
- Per-channel edge or level detection, a mask register and fixed priority (lowest index highest).
- Runs a request/acknowledge/end-of-interrupt handshake with the CPU control unit and supplies a registered channel id and ISR vector for PC load.

Parameters:
NUM_IRQ, 8, number of interrupt channels (1..2**ID_W)
ID_W, 3, width of channel id output
EDGE_MASK, 8'hF0, bit i = 1: channel i rising-edge triggered; 0: level triggered
VEC_BASE, 32'h0000_0400, vector of channel 0
VEC_STRIDE, 8, byte distance between consecutive channel vectors
MASK_RST, all ones, reset value of the mask register

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  reset, synchronous, active-high
irq  input  NUM_IRQ  raw interrupt lines, synchronous to clk
ie  input  1  CPU interrupt enable
mask_we  input  1  mask register write strobe
mask_wdata  input  NUM_IRQ  new mask value (1 = enabled)
mask_q  output  NUM_IRQ  current mask
pending_q  output  NUM_IRQ  current pending register
intr  output  1  interrupt request to CPU (registered)
intr_ack  input  1  one-cycle CPU acknowledge
intr_id  output  ID_W  id of requested/serviced channel (registered)
intr_vec  output  32  ISR address (registered)
eoi  input  1  one-cycle end-of-interrupt (LISR) from CPU
in_service  output  1  high while ISR is active

Behaviour:
- Reset (rst=1 at an edge, any state): state=IDLE, intr=0, in_service=0, intr_id=0, intr_vec=VEC_BASE, pending=0, irq_d=0, mask=MASK_RST. Reset mid-handshake abandons it; no ack/eoi needed afterwards.
- Edge channel i: pending[i] set at an edge where irq[i]=1 and irq_d[i]=0 (irq_d = irq registered every cycle). Cleared only by ack of channel i. Set wins over clear in the same cycle.
- Level channel i: pending[i] <= irq[i] every cycle. Ack has no effect; the source must drop irq before eoi.
- mask_we: mask <= mask_wdata at that edge. Masking never clears pending.
- eligible = pending & mask. Winner = lowest index set in eligible.
- FSM states: IDLE, REQ, SERVICE.
- IDLE -> REQ when ie=1 and eligible!=0. Same edge: intr<=1, intr_id<=winner, intr_vec<=VEC_BASE+winner*VEC_STRIDE (32-bit, wraps mod 2**32).
- REQ: intr, intr_id, intr_vec held stable. Not re-arbitrated on higher-priority arrival, ie drop, masking or level withdrawal.
- REQ, intr_ack=1: go to SERVICE. intr<=0, in_service<=1, pending[intr_id] cleared if edge channel. intr_id/intr_vec held.
- SERVICE, eoi=1: go to IDLE, in_service<=0.
- intr_ack outside REQ and eoi outside SERVICE are ignored. intr_ack and eoi together in REQ: only the ack acts.
- Latency: irq sampled high at edge k -> pending at edge k -> intr high after edge k+1. After eoi at edge m, the earliest next intr is after edge m+1 (one IDLE cycle).
- No nesting: new requests during REQ/SERVICE accumulate in pending and are arbitrated on return to IDLE.

Test Plan:
- Reset then irq=8'h10 pulse for one cycle, ie=1 -> pending_q=8'h10 next cycle; intr=1, intr_id=4, intr_vec=32'h0420 one cycle later. Ack -> intr=0, in_service=1, pending_q=0. Eoi -> in_service=0.
- irq=8'h0A held (level), ie=1 -> intr_id=1, vec=32'h0408. Ack, drop irq[1], eoi -> next request intr_id=3, vec=32'h0418 after one IDLE cycle.
- mask_wdata=8'hEF, irq[4] pulse -> pending_q=8'h10, intr stays 0. Write mask 8'hFF -> intr=1, id=4 two cycles later.
- In REQ with id=5, irq[0] raised (level) -> id stays 5 until ack. After eoi, id=0 is served.
- ie=0 with pending 8'h20 -> intr=0 indefinitely. Set ie=1 -> intr=1 next cycle, id=5. New irq[5] edge coincident with ack -> pending[5] remains 1.
- Assert rst in SERVICE with pending 8'h80 -> all outputs at reset values next cycle, mask=8'hFF, no intr without new irq.
